// File: rtl/async_fifo_param.sv
// Dual-clock FIFO with Gray-coded pointer crossing, registered flags and levels.
// Write state runs on w_clk and read state on r_clk; both reset synchronously.
module async_fifo_param #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AF_THRESH   = 14,
   parameter int AE_THRESH   = 2
) (
   input  logic              w_clk,
   input  logic              reset,
   input  logic              r_clk,
   input  logic [DATA_W-1:0] wdata,
   input  logic              w_en,
   output logic              full,
   output logic              almost_full,
   output logic [ADDR_W:0]   wr_level,
   output logic              overflow,
   input  logic              r_en,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              empty,
   output logic              almost_empty,
   output logic [ADDR_W:0]   rd_level,
   output logic              underflow
);

   localparam int PW    = ADDR_W + 1;
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

   function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] to_bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr, wr_gray, wr_ptr_nx, wr_gray_nx;
   logic [PW-1:0] rd_ptr, rd_gray, rd_ptr_nx, rd_gray_nx;
   logic [PW-1:0] rd_sync [SYNC_STAGES];
   logic [PW-1:0] wr_sync [SYNC_STAGES];
   logic [PW-1:0] rd_sync_g, wr_sync_g;
   logic [PW-1:0] wr_level_nx, rd_level_nx;
   logic          push, pop, full_nx, empty_nx;

   // Write domain
   assign push        = w_en && !full;
   assign wr_ptr_nx   = wr_ptr + {{ADDR_W{1'b0}}, push};
   assign wr_gray_nx  = to_gray(wr_ptr_nx);
   assign rd_sync_g   = rd_sync[SYNC_STAGES-1];
   assign wr_level_nx = wr_ptr_nx - to_bin(rd_sync_g);
   // Full when the writer is exactly one lap ahead of the reader
   assign full_nx     = wr_gray_nx ==
                        {~rd_sync_g[PW-1 -: 2], rd_sync_g[PW-3:0]};

   always_ff @(posedge w_clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         wr_gray     <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_level    <= '0;
         overflow    <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) rd_sync[i] <= '0;
      end else begin
         wr_ptr      <= wr_ptr_nx;
         wr_gray     <= wr_gray_nx;
         full        <= full_nx;
         almost_full <= wr_level_nx >= AF_LVL;
         wr_level    <= wr_level_nx;
         if (w_en && full) overflow <= 1'b1;
         rd_sync[0] <= rd_gray;
         for (int i = 1; i < SYNC_STAGES; i++) rd_sync[i] <= rd_sync[i-1];
      end
   end

   always_ff @(posedge w_clk) begin
      if (push) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
   end

   // Read domain
   assign pop         = r_en && !empty;
   assign rd_ptr_nx   = rd_ptr + {{ADDR_W{1'b0}}, pop};
   assign rd_gray_nx  = to_gray(rd_ptr_nx);
   assign wr_sync_g   = wr_sync[SYNC_STAGES-1];
   assign rd_level_nx = to_bin(wr_sync_g) - rd_ptr_nx;
   assign empty_nx    = rd_gray_nx == wr_sync_g;

   always_ff @(posedge r_clk) begin
      if (reset) begin
         rd_ptr       <= '0;
         rd_gray      <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_level     <= '0;
         underflow    <= 1'b0;
         rvalid       <= 1'b0;
         rdata        <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) wr_sync[i] <= '0;
      end else begin
         rd_ptr       <= rd_ptr_nx;
         rd_gray      <= rd_gray_nx;
         empty        <= empty_nx;
         almost_empty <= rd_level_nx <= AE_LVL;
         rd_level     <= rd_level_nx;
         rvalid       <= pop;
         if (pop) rdata <= mem[rd_ptr[ADDR_W-1:0]];
         if (r_en && empty) underflow <= 1'b1;
         wr_sync[0] <= wr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) wr_sync[i] <= wr_sync[i-1];
      end
   end

endmodule
